line_follow_ctrl: RTL
=====================

Name: line_follow_ctrl

Overview:
- Steering controller for the line follower.
- Consumes the three synchronized sensor bits from the input synchronizer.
- Filters them for stability, then decides a motor command once per control period with a state machine.
- Drives the left and right motor command codes to the motor/PWM stage. Handles line loss with a directional search and a halt timeout.

Parameters:
- PERIOD, 2000000, clock cycles per control tick (20 ms at 100 MHz); must be at least 2.
- STABLE_CYCLES, 1000, consecutive identical raw samples required before the filtered pattern updates; must be at least 1.
- LOST_TICKS, 50, control ticks spent searching before halting; must be at least 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run control; low forces IDLE
- sensor_l  in  1  left sensor, synchronized, 1 = line seen
- sensor_m  in  1  middle sensor, synchronized
- sensor_r  in  1  right sensor, synchronized
- motor_l_cmd  out  2  left motor command: 00 stop, 01 forward, 10 reverse, 11 reserved (never driven)
- motor_r_cmd  out  2  right motor command, same encoding
- cmd_update  out  1  one-cycle pulse when a new command is registered
- lost  out  1  high while in SEARCH or HALT

Behaviour:
- Reset (reset_n low, asynchronous):
  - All counters cleared; state IDLE; last_side = LEFT; filtered pattern = 000.
  - Outputs: motor cmds 00, cmd_update 0, lost 0.
- Stability filter:
  - Raw pattern {l,m,r} is compared with the previous raw sample each cycle.
  - A mismatch clears the stable counter. A match increments it, saturating at STABLE_CYCLES.
  - When the count reaches STABLE_CYCLES, the filtered pattern takes the raw value.
  - The filter runs regardless of enable.
- Tick counter:
  - Counts 0..PERIOD-1 and wraps; tick is asserted when the count equals PERIOD-1.
  - Held at 0 while enable is low.
- States: IDLE, FORWARD, GENTLE_L, SHARP_L, GENTLE_R, SHARP_R, SEARCH, HALT.
- Decode, evaluated only on tick using the filtered pattern lmr:
  - 010 or 111 -> FORWARD
  - 110 -> GENTLE_L, last_side=LEFT
  - 100 -> SHARP_L, last_side=LEFT
  - 011 -> GENTLE_R, last_side=RIGHT
  - 001 -> SHARP_R, last_side=RIGHT
  - 101 -> hold current state; if current is IDLE/SEARCH/HALT, go to FORWARD
  - 000 -> SEARCH from any state except HALT; from HALT, stay in HALT
- SEARCH:
  - The lost counter is cleared on entry and incremented each tick while the pattern stays 000.
  - At count LOST_TICKS -> HALT.
  - Any non-000 pattern on a tick -> decoded state; lost counter cleared.
- HALT: motors stop; leaves only on a tick with a non-000 pattern.
- IDLE:
  - Entered immediately (next clock) whenever enable=0, from any state; clears the lost counter.
  - With enable=1, the first tick decodes normally.
- Command map (left, right):
  - IDLE/HALT: 00,00
  - FORWARD: 01,01
  - GENTLE_L: 00,01
  - SHARP_L: 10,01
  - GENTLE_R: 01,00
  - SHARP_R: 01,10
  - SEARCH: spin toward last_side (LEFT -> 10,01; RIGHT -> 01,10)
- Timing:
  - Outputs are registered and change on the clock edge after the tick.
  - cmd_update pulses on that same edge for every tick, even if the command is unchanged.
  - cmd_update also pulses on entry to IDLE.
  - lost is registered alongside the commands.
- Simultaneous events:
  - enable falling on a tick cycle -> IDLE wins.
  - Raw change on a tick cycle -> the tick uses the previous filtered value.

Decomposition:
- Package line_follow_pkg holds:
  - state enum (3 bits)
  - motor command typedef and constants MOTOR_STOP/FWD/REV
  - side enum LEFT/RIGHT
  - decode function pattern -> state
- Sub-module sensor_stability_filter (parameter STABLE_CYCLES; 3-bit raw in, 3-bit filtered out). Instantiated once.

Test Plan:
- Parameters for all directed tests: PERIOD=10, STABLE_CYCLES=3, LOST_TICKS=4.
- Reset, then enable=1 with raw 010 held -> first tick after filter settles gives motor cmds 01/01, cmd_update one cycle, lost=0.
- Raw 110 then 100, each held 3 periods -> GENTLE_L (00/01) then SHARP_L (10/01); 2-cycle glitch to 001 mid-period is ignored and the command stays 10/01.
- After 011, raw 000 -> SEARCH with cmds 01/10 and lost=1; after 4 further ticks -> HALT, cmds 00/00, lost=1; raw 010 -> FORWARD on the next tick, lost=0.
- In SHARP_R, drive 101 -> state held (01/10); from HALT, drive 101 -> FORWARD.
- enable low mid-period in GENTLE_R -> next clock cmds 00/00 plus cmd_update; tick counter holds at 0 while low.
- reset_n asserted asynchronously mid-SEARCH -> outputs 00/00 and lost=0 immediately; last_side returns to LEFT (a later search spins 10/01).

Source files
------------

// File: rtl/line_follow_pkg.sv
// line_follow_pkg: shared state, motor command and side types plus the sensor pattern decoder
// Holds no ports: imported by the steering controller and its interface.
package line_follow_pkg;
  typedef enum logic [2:0] {IDLE, FORWARD, GENTLE_L, SHARP_L, GENTLE_R, SHARP_R, SEARCH, HALT} state_t;
  typedef logic [1:0] motor_t;
  localparam motor_t MOTOR_STOP = 2'b00;
  localparam motor_t MOTOR_FWD  = 2'b01;
  localparam motor_t MOTOR_REV  = 2'b10;
  typedef enum logic {LEFT, RIGHT} side_t;
  // 101 (line under both outer sensors) keeps any steering state, but a
  // non-steering state has nothing to keep, so it falls back to FORWARD.
  function automatic state_t decode(input logic [2:0] p, input state_t cur);
    return (p == 3'b010 || p == 3'b111) ? FORWARD :
           p == 3'b110 ? GENTLE_L :
           p == 3'b100 ? SHARP_L :
           p == 3'b011 ? GENTLE_R :
           p == 3'b001 ? SHARP_R :
           p == 3'b101 ? ((cur == IDLE || cur == SEARCH || cur == HALT) ? FORWARD : cur) :
           (cur == HALT ? HALT : SEARCH);
  endfunction
endpackage

// File: rtl/line_follow_ctrl_if.sv
// line_follow_ctrl_if: bundle between sensor/enable source and the steering controller
// Ports: enable, sensor_l/m/r (to controller); motor_l_cmd, motor_r_cmd, cmd_update, lost (from controller).
interface line_follow_ctrl_if;
  logic enable;
  logic sensor_l;
  logic sensor_m;
  logic sensor_r;
  line_follow_pkg::motor_t motor_l_cmd;
  line_follow_pkg::motor_t motor_r_cmd;
  logic cmd_update;
  logic lost;
  modport master(output enable, sensor_l, sensor_m, sensor_r, input motor_l_cmd, motor_r_cmd, cmd_update, lost);
  modport slave(input enable, sensor_l, sensor_m, sensor_r, output motor_l_cmd, motor_r_cmd, cmd_update, lost);
endinterface

// File: rtl/sensor_stability_filter.sv
// sensor_stability_filter: passes the raw pattern only after STABLE_CYCLES consecutive matching samples
// Ports: clk, reset_n (async active-low), raw[2:0] in, filtered[2:0] out.
module sensor_stability_filter #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] raw,
  output logic [2:0] filtered
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  logic [2:0] prev;
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb cnt_nxt = raw != prev ? '0 : cnt == CMAX ? CMAX : cnt + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      cnt <= '0;
      filtered <= '0;
    end else begin
      prev <= raw;
      cnt <= cnt_nxt;
      if (cnt_nxt == CMAX) filtered <= raw;
    end
  end
endmodule

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: line follower steering FSM with stability filter, control tick, search and halt
// Ports: clk, reset_n (async active-low), bus (slave): enable, sensor_l/m/r in; motor_l_cmd, motor_r_cmd, cmd_update, lost out.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int PERIOD        = 2000000,
  parameter int STABLE_CYCLES = 1000,
  parameter int LOST_TICKS    = 50
) (
  input logic               clk,
  input logic               reset_n,
  line_follow_ctrl_if.slave bus
);
  localparam int TW = $clog2(PERIOD);
  localparam int LW = $clog2(LOST_TICKS + 1);
  localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOST_TICKS);
  logic [2:0] filt;
  logic [TW-1:0] tick_cnt;
  logic [LW-1:0] lost_cnt, lost_nxt;
  state_t state, nxt;
  side_t side, side_nxt;
  logic tick, upd;
  motor_t ml, mr;
  sensor_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw      ({bus.sensor_l, bus.sensor_m, bus.sensor_r}),
    .filtered (filt)
  );
  assign tick = bus.enable && tick_cnt == TLAST;
  always_comb begin
    nxt = state;
    side_nxt = side;
    lost_nxt = lost_cnt;
    upd = 1'b0;
    if (!bus.enable) begin
      nxt = IDLE;
      lost_nxt = '0;
      upd = state != IDLE;
    end else if (tick) begin
      upd = 1'b1;
      if (filt == 3'b000 && state == SEARCH) begin
        lost_nxt = lost_cnt + 1'b1;
        nxt = lost_nxt == LMAX ? HALT : SEARCH;
      end else begin
        nxt = decode(filt, state);
        lost_nxt = '0;
        side_nxt = (filt == 3'b110 || filt == 3'b100) ? LEFT :
                   (filt == 3'b011 || filt == 3'b001) ? RIGHT : side;
      end
    end
  end
  // Commands are derived from the next state so they register on the same edge as the state.
  always_comb begin
    ml = (nxt == FORWARD || nxt == GENTLE_R || nxt == SHARP_R || (nxt == SEARCH && side_nxt == RIGHT)) ? MOTOR_FWD :
         (nxt == SHARP_L || (nxt == SEARCH && side_nxt == LEFT)) ? MOTOR_REV : MOTOR_STOP;
    mr = (nxt == FORWARD || nxt == GENTLE_L || nxt == SHARP_L || (nxt == SEARCH && side_nxt == LEFT)) ? MOTOR_FWD :
         (nxt == SHARP_R || (nxt == SEARCH && side_nxt == RIGHT)) ? MOTOR_REV : MOTOR_STOP;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      state <= IDLE;
      side <= LEFT;
      lost_cnt <= '0;
      bus.motor_l_cmd <= MOTOR_STOP;
      bus.motor_r_cmd <= MOTOR_STOP;
      bus.cmd_update <= 1'b0;
      bus.lost <= 1'b0;
    end else begin
      tick_cnt <= (!bus.enable || tick) ? '0 : tick_cnt + 1'b1;
      state <= nxt;
      side <= side_nxt;
      lost_cnt <= lost_nxt;
      bus.motor_l_cmd <= ml;
      bus.motor_r_cmd <= mr;
      bus.cmd_update <= upd;
      bus.lost <= nxt == SEARCH || nxt == HALT;
    end
  end
endmodule
